i2c_master_ctrl: RTL and testbench

//  Single-byte I2C master sequencer that runs the existing clk_generator: programs its divider
//  (limit), gates it (f_state), and uses its en pulse as the quarter-SCL tick. Sends START,
//  7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP on open-drain SCL/SDA. Sits in
//  i2c_master_top next to clk_generator; the vacuum-cleaner sensor/motor logic issues requests.

---
 rtl/i2c_master_ctrl_pkg.sv | 29 ++
 rtl/i2c_master_ctrl_if.sv | 16 +
 rtl/i2c_master_ctrl.sv | 150 +++++++++++++++
 tb/tb_i2c_master_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_ctrl_pkg.sv
// Shared encodings for the single-byte I2C master sequencer: FSM states,
// quarter-SCL phases, divider defaults and the host request record.
package i2c_master_ctrl_pkg;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_AACK  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_DACK  = 3'd5;
  localparam logic [2:0] S_STOP  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  localparam logic [1:0] P_DRIVE  = 2'd0;
  localparam logic [1:0] P_RISE   = 2'd1;
  localparam logic [1:0] P_SAMPLE = 2'd2;
  localparam logic [1:0] P_FALL   = 2'd3;

  localparam logic [15:0] LIMIT_STD_DEF  = 16'd250;
  localparam logic [15:0] LIMIT_FAST_DEF = 16'd63;

  typedef struct packed {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic       fast;
  } i2c_req_t;

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Host-side request/response bundle between the sensor/motor logic and the
// I2C master sequencer.
interface i2c_master_ctrl_if;
  import i2c_master_ctrl_pkg::*;

  logic       start;
  i2c_req_t   req;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rd_data;

  modport master (output start, req, input busy, done, ack_err, rd_data);
  modport slave  (input start, req, output busy, done, ack_err, rd_data);

endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Advances only on the clk_generator quarter-SCL tick; drives open-drain enables.
module i2c_master_ctrl
  import i2c_master_ctrl_pkg::*;
#(
  parameter logic [15:0] LIMIT_STD  = LIMIT_STD_DEF,
  parameter logic [15:0] LIMIT_FAST = LIMIT_FAST_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  i2c_master_ctrl_if.slave    host,
  output logic                cg_run,
  output logic [15:0]         cg_limit,
  input  logic                tick,
  output logic                scl_oe,
  output logic                sda_oe,
  input  logic                sda_i
);

  logic [2:0]  state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic [2:0]  bit_q, bit_d;
  logic        rw_q, rw_d;
  logic [7:0]  abyte_q, abyte_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic [7:0]  rd_q, rd_d;
  logic        ack_err_q, ack_err_d;
  logic        scl_q, scl_d;
  logic        sda_q, sda_d;
  logic [15:0] lim_q, lim_d;
  logic        tx_bit;
  logic        drive_en;

  assign tx_bit   = (state_q == S_ADDR) ? abyte_q[bit_q] : wbyte_q[bit_q];
  // Master owns SDA only for address bits and written data bits.
  assign drive_en = (state_q == S_ADDR) || (state_q == S_DATA && !rw_q);

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    rw_d      = rw_q;
    abyte_d   = abyte_q;
    wbyte_d   = wbyte_q;
    rd_d      = rd_q;
    ack_err_d = ack_err_q;
    scl_d     = scl_q;
    sda_d     = sda_q;
    lim_d     = lim_q;
    if (state_q == S_IDLE) begin
      if (host.start) begin
        state_d   = S_START;
        ph_d      = P_DRIVE;
        bit_d     = 3'd7;
        rw_d      = host.req.rw;
        abyte_d   = {host.req.addr, host.req.rw};
        wbyte_d   = host.req.data;
        lim_d     = host.req.fast ? LIMIT_FAST : LIMIT_STD;
        ack_err_d = 1'b0;
      end
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end else if (tick) begin
      ph_d = ph_q + 2'd1;
      case (state_q)
        S_START: begin
          if (ph_q == P_DRIVE) begin
            sda_d = 1'b1;
          end else begin
            scl_d   = 1'b1;
            ph_d    = P_DRIVE;
            state_d = S_ADDR;
          end
        end
        S_STOP: begin
          case (ph_q)
            P_DRIVE:  begin scl_d = 1'b1; sda_d = 1'b1; end
            P_RISE:   scl_d = 1'b0;
            P_SAMPLE: sda_d = 1'b0;
            default:  state_d = S_DONE;
          endcase
        end
        default: begin
          case (ph_q)
            P_DRIVE:  sda_d = drive_en ? ~tx_bit : 1'b0;
            P_RISE:   scl_d = 1'b0;
            P_SAMPLE: begin
              if (state_q == S_AACK && sda_i)            ack_err_d = 1'b1;
              if (state_q == S_DACK && !rw_q && sda_i)   ack_err_d = 1'b1;
              if (state_q == S_DATA && rw_q)             rd_d = {rd_q[6:0], sda_i};
            end
            default: begin
              scl_d = 1'b1;
              case (state_q)
                S_ADDR: begin
                  bit_d = bit_q - 3'd1;
                  if (bit_q == 3'd0) state_d = S_AACK;
                end
                S_AACK: state_d = ack_err_q ? S_STOP : S_DATA;
                S_DATA: begin
                  bit_d = bit_q - 3'd1;
                  if (bit_q == 3'd0) state_d = S_DACK;
                end
                default: state_d = S_STOP;
              endcase
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ph_q      <= P_DRIVE;
      bit_q     <= 3'd7;
      rw_q      <= 1'b0;
      abyte_q   <= '0;
      wbyte_q   <= '0;
      rd_q      <= '0;
      ack_err_q <= 1'b0;
      scl_q     <= 1'b0;
      sda_q     <= 1'b0;
      lim_q     <= LIMIT_STD;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      rw_q      <= rw_d;
      abyte_q   <= abyte_d;
      wbyte_q   <= wbyte_d;
      rd_q      <= rd_d;
      ack_err_q <= ack_err_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      lim_q     <= lim_d;
    end
  end

  assign host.busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign host.done    = (state_q == S_DONE);
  assign host.ack_err = ack_err_q;
  assign host.rd_data = rd_q;
  assign cg_run       = host.busy;
  assign cg_limit     = lim_q;
  assign scl_oe       = scl_q;
  assign sda_oe       = sda_q;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench: divider tick model, open-drain pull-ups and a byte-level slave.
module tb_i2c_master_ctrl;
  import i2c_master_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cg_run, tick, scl_oe, sda_oe, sda_i;
  logic [15:0] cg_limit;
  logic        scl, sda;
  logic        force_tick = 1'b0;
  logic        slv_pull = 1'b0;
  logic        slv_en = 1'b1;
  logic [7:0]  slv_rd = 8'h00;
  logic [1:0]  gcnt = '0;
  logic        gen_tick;
  int          tick_cnt = 0, done_cnt = 0;
  int          slot = -2, rises = 0;
  logic [17:0] sda_log = '0;
  logic [7:0]  cap = '0;
  logic        scl_p = 1'b1, sda_p = 1'b1;
  int          n_vec = 0, n_err = 0;
  int          t0, d0;

  i2c_master_ctrl_if hst();

  i2c_master_ctrl dut (
    .clk(clk), .rst_n(rst_n), .host(hst),
    .cg_run(cg_run), .cg_limit(cg_limit), .tick(tick),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 clk = ~clk;

  assign scl   = ~scl_oe;
  assign sda   = ~(sda_oe | slv_pull);
  assign sda_i = sda;

  // Short divider so a transaction is ~312 clocks; tick every 4th clock while run.
  always @(posedge clk) begin
    if (!cg_run) gcnt <= '0;
    else         gcnt <= gcnt + 2'd1;
  end
  assign gen_tick = cg_run && (gcnt == 2'd3);
  assign tick     = gen_tick | force_tick;

  always @(posedge clk) begin
    if (tick && hst.busy) tick_cnt <= tick_cnt + 1;
    if (hst.done)         done_cnt <= done_cnt + 1;
  end

  function automatic logic pull_for(input int s);
    if (!slv_en)            return 1'b0;
    if (s == 8)             return 1'b1;
    if (s >= 9 && s <= 16)  return cap[0] & ~slv_rd[16 - s];
    if (s == 17)            return ~cap[0];
    return 1'b0;
  endfunction

  // Slave: slot index advances on each SCL fall after START; changes SDA only with SCL low.
  always @(posedge clk) begin
    if (!rst_n) begin
      slot     <= -2;
      slv_pull <= 1'b0;
    end else if (scl_p && scl && sda_p && !sda) begin
      slot    <= -1;
      rises   <= 0;
      sda_log <= '0;
    end else if (scl_p && !scl) begin
      slot     <= slot + 1;
      slv_pull <= pull_for(slot + 1);
    end else if (!scl_p && scl) begin
      rises <= rises + 1;
      if (slot >= 0 && slot <= 17) sda_log <= {sda_log[16:0], sda};
      if (slot >= 0 && slot <= 7)  cap     <= {cap[6:0], sda};
    end
    scl_p <= scl;
    sda_p <= sda;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic kick(input logic rw, input logic [6:0] a, input logic [7:0] d, input logic f);
    @(negedge clk);
    hst.req.rw   = rw;
    hst.req.addr = a;
    hst.req.data = d;
    hst.req.fast = f;
    hst.start    = 1'b1;
    t0 = tick_cnt;
    d0 = done_cnt;
    @(negedge clk);
    hst.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!hst.done && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, (i < 4000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int i;
    hst.start = 1'b0;
    hst.req   = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  hst.busy, 0);
    chk("rst_done",  hst.done, 0);
    chk("rst_aerr",  hst.ack_err, 0);
    chk("rst_rd",    hst.rd_data, 0);
    chk("rst_run",   cg_run, 0);
    chk("rst_scl",   scl_oe, 0);
    chk("rst_sda",   sda_oe, 0);
    chk("rst_lim",   cg_limit, 250);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 1: write 0x50 <- 0xA5, slave ACKs
    slv_en = 1'b1;
    kick(1'b0, 7'h50, 8'hA5, 1'b0);
    chk("t1_busy", hst.busy, 1);
    chk("t1_run",  cg_run, 1);
    chk("t1_lim",  cg_limit, 250);
    wait_done("t1_done_to");
    chk("t1_ticks", tick_cnt - t0, 78);
    chk("t1_busy_at_done", hst.busy, 0);
    chk("t1_run_at_done",  cg_run, 0);
    chk("t1_aerr", hst.ack_err, 0);
    chk("t1_bits", sda_log, {7'h50, 1'b0, 1'b0, 8'hA5, 1'b0});
    chk("t1_rises", rises, 19);
    @(negedge clk);
    chk("t1_done_1clk", hst.done, 0);

    // 2: read 0x50, slave returns 0x3C, master NACKs
    slv_rd = 8'h3C;
    kick(1'b1, 7'h50, 8'h00, 1'b0);
    wait_done("t2_done_to");
    chk("t2_ticks", tick_cnt - t0, 78);
    chk("t2_rd",    hst.rd_data, 8'h3C);
    chk("t2_aerr",  hst.ack_err, 0);
    chk("t2_bits",  sda_log, {7'h50, 1'b1, 1'b0, 8'h3C, 1'b1});
    repeat (2) @(negedge clk);
    chk("t2_rd_hold", hst.rd_data, 8'h3C);

    // 3: no slave -> address NACK, STOP straight after AACK
    slv_en = 1'b0;
    kick(1'b0, 7'h22, 8'h5A, 1'b0);
    wait_done("t3_done_to");
    chk("t3_ticks", tick_cnt - t0, 42);
    chk("t3_aerr",  hst.ack_err, 1);
    chk("t3_rises", rises, 10);
    chk("t3_scl_oe", scl_oe, 0);
    chk("t3_sda_oe", sda_oe, 0);
    chk("t3_lines", {scl, sda}, 2'b11);
    repeat (3) @(negedge clk);
    chk("t3_aerr_hold", hst.ack_err, 1);
    slv_en = 1'b1;

    // 4: fast mode, second start mid-transfer ignored
    kick(1'b0, 7'h50, 8'hA5, 1'b1);
    chk("t4_lim",  cg_limit, 63);
    chk("t4_aerr_clr", hst.ack_err, 0);
    repeat (40) @(negedge clk);
    hst.req.addr = 7'h11;
    hst.req.fast = 1'b0;
    hst.start    = 1'b1;
    @(negedge clk);
    hst.start = 1'b0;
    chk("t4_lim_hold", cg_limit, 63);
    wait_done("t4_done_to");
    chk("t4_ticks", tick_cnt - t0, 78);
    chk("t4_bits",  sda_log, {7'h50, 1'b0, 1'b0, 8'hA5, 1'b0});
    repeat (30) @(negedge clk);
    chk("t4_one_done", done_cnt - d0, 1);
    chk("t4_idle", hst.busy, 0);

    // 6: ticks in IDLE, then start and tick in the same cycle
    force_tick = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6_idle_scl", scl_oe, 0);
    chk("t6_idle_sda", sda_oe, 0);
    chk("t6_idle_busy", hst.busy, 0);
    hst.req.rw   = 1'b0;
    hst.req.addr = 7'h50;
    hst.req.data = 8'hA5;
    hst.req.fast = 1'b0;
    hst.start    = 1'b1;
    t0 = tick_cnt;
    @(negedge clk);
    hst.start  = 1'b0;
    force_tick = 1'b0;
    chk("t6_busy", hst.busy, 1);
    chk("t6_no_start_yet", sda_oe, 0);
    chk("t6_lim", cg_limit, 250);
    force_tick = 1'b1;
    @(negedge clk);
    force_tick = 1'b0;
    chk("t6_start_sda", sda_oe, 1);
    chk("t6_start_scl", scl_oe, 0);
    wait_done("t6_done_to");
    chk("t6_ticks", tick_cnt - t0, 78);
    chk("t6_aerr", hst.ack_err, 0);

    // 5: async reset during DATA bit 4, then a clean transaction
    kick(1'b0, 7'h50, 8'hA5, 1'b0);
    i = 0;
    while (slot != 12 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    chk("t5_reach_bit4", (i < 2000) ? 32'd1 : 32'd0, 32'd1);
    repeat (6) @(negedge clk);
    chk("t5_pre_sda", sda_oe, 1);
    chk("t5_pre_scl", scl_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_scl",  scl_oe, 0);
    chk("t5_rst_sda",  sda_oe, 0);
    chk("t5_rst_run",  cg_run, 0);
    chk("t5_rst_busy", hst.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_lines", {scl, sda}, 2'b11);
    kick(1'b0, 7'h50, 8'hA5, 1'b0);
    wait_done("t5_done_to");
    chk("t5_ticks", tick_cnt - t0, 78);
    chk("t5_aerr",  hst.ack_err, 0);
    chk("t5_bits",  sda_log, {7'h50, 1'b0, 1'b0, 8'hA5, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
